// File: rtl/cordic_pkg.sv
// Shared vectoring CORDIC constants: angle width, pi/2, 1/K and atan table.
// The GAIN state exists only when GAIN_COMP_EN is defined.
package cordic_pkg;

  localparam int unsigned ATAN_DEPTH = 32;
  localparam logic [34:0] PI_2 = 35'd6746518852;
  localparam logic [31:0] INV_K = 32'h9B74EDA8;

  // atan(2^-i) in Q0.32 radians
  localparam logic [31:0] ATAN_TAB [ATAN_DEPTH] = '{
    32'd3373259426, 32'd1991351318, 32'd1052175346, 32'd534100635,
    32'd268086748,  32'd134174063,  32'd67103403,   32'd33553749,
    32'd16777131,   32'd8388597,    32'd4194303,    32'd2097152,
    32'd1048576,    32'd524288,     32'd262144,     32'd131072,
    32'd65536,      32'd32768,      32'd16384,      32'd8192,
    32'd4096,       32'd2048,       32'd1024,       32'd512,
    32'd256,        32'd128,        32'd64,         32'd32,
    32'd16,         32'd8,          32'd4,          32'd2
  };

  function automatic int angle_width(input int bw);
    return bw + 3;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
`ifdef GAIN_COMP_EN
    ST_GAIN = 2'd2,
`endif
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational atan(2^-i) lookup, Q0.32 radians.
module cordic_atan_rom
  import cordic_pkg::*;
(
  input  logic [4:0]  idx_i,
  output logic [31:0] atan_o
);

  assign atan_o = ATAN_TAB[idx_i];

endmodule

// File: rtl/cordic_vectoring_iter.sv
// Iterative vectoring CORDIC: (x,y) -> magnitude, atan2(y,x).
// Define GAIN_COMP_EN to scale the magnitude by 1/K in an extra GAIN state.
module cordic_vectoring_iter
  import cordic_pkg::*;
#(
  parameter int BIT_WIDTH = 32,
  parameter int ITERATIONS = 32,
  localparam int ANGLE_WIDTH = angle_width(BIT_WIDTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [BIT_WIDTH-1:0]   x_in,
  input  logic signed [BIT_WIDTH-1:0]   y_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BIT_WIDTH+1:0]          mag_out,
  output logic signed [ANGLE_WIDTH-1:0] angle_out,
  output logic                          zero_out
);

  localparam int XW = BIT_WIDTH + 2;
  localparam int AW = ANGLE_WIDTH;
  localparam logic [4:0] LAST = 5'(ITERATIONS - 1);
  localparam logic signed [AW-1:0] PI2_A = AW'(PI_2);

  state_e state_q, state_d;
  logic [4:0] iter_q, iter_d;
  logic signed [XW-1:0] x_q, x_d, y_q, y_d;
  logic signed [AW-1:0] z_q, z_d;
  logic zero_q, zero_d;
  logic vld_q, vld_d;
  logic zout_q, zout_d;
  logic [XW-1:0] mag_q, mag_d;
  logic signed [AW-1:0] ang_q, ang_d;

  logic signed [XW-1:0] xe, ye, xsh, ysh;
  logic signed [AW-1:0] dz;
  logic [31:0] atan;

  cordic_atan_rom u_rom (
    .idx_i (iter_q),
    .atan_o(atan)
  );

  assign xe = XW'(x_in);
  assign ye = XW'(y_in);
  assign xsh = x_q >>> iter_q;
  assign ysh = y_q >>> iter_q;
  assign dz = AW'({1'b0, atan});

`ifdef GAIN_COMP_EN
  logic [XW+31:0] prod;
  // x is non-negative here; +2^31 rounds half-up
  assign prod = (XW+32)'($unsigned(x_q)) * (XW+32)'(INV_K)
              + (XW+32)'(32'h8000_0000);
`endif

  always_comb begin
    state_d = state_q;
    iter_d = iter_q;
    x_d = x_q;
    y_d = y_q;
    z_d = z_q;
    zero_d = zero_q;
    vld_d = vld_q;
    zout_d = zout_q;
    mag_d = mag_q;
    ang_d = ang_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_ITER;
          iter_d = '0;
          zero_d = (x_in == '0) && (y_in == '0);
          // fold left half-plane into the right; y=0 goes to +pi
          if (!xe[XW-1]) begin
            x_d = xe;
            y_d = ye;
            z_d = '0;
          end else if (!ye[XW-1]) begin
            x_d = ye;
            y_d = -xe;
            z_d = PI2_A;
          end else begin
            x_d = -ye;
            y_d = xe;
            z_d = -PI2_A;
          end
        end
      end
      ST_ITER: begin
        if (!y_q[XW-1]) begin
          x_d = x_q + ysh;
          y_d = y_q - xsh;
          z_d = z_q + dz;
        end else begin
          x_d = x_q - ysh;
          y_d = y_q + xsh;
          z_d = z_q - dz;
        end
        iter_d = iter_q + 5'd1;
        if (iter_q == LAST) begin
          iter_d = '0;
`ifdef GAIN_COMP_EN
          state_d = ST_GAIN;
`else
          state_d = ST_DONE;
`endif
        end
      end
`ifdef GAIN_COMP_EN
      ST_GAIN: begin
        x_d = XW'(prod >> 32);
        state_d = ST_DONE;
      end
`endif
      ST_DONE: begin
        if (!vld_q) begin
          vld_d = 1'b1;
          zout_d = zero_q;
          mag_d = zero_q ? '0 : $unsigned(x_q);
          ang_d = zero_q ? '0 : z_q;
        end else if (out_ready) begin
          vld_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      iter_q <= '0;
      x_q <= '0;
      y_q <= '0;
      z_q <= '0;
      zero_q <= 1'b0;
      vld_q <= 1'b0;
      zout_q <= 1'b0;
      mag_q <= '0;
      ang_q <= '0;
    end else begin
      state_q <= state_d;
      iter_q <= iter_d;
      x_q <= x_d;
      y_q <= y_d;
      z_q <= z_d;
      zero_q <= zero_d;
      vld_q <= vld_d;
      zout_q <= zout_d;
      mag_q <= mag_d;
      ang_q <= ang_d;
    end
  end

  assign in_ready = (state_q == ST_IDLE);
  assign out_valid = vld_q;
  assign mag_out = mag_q;
  assign angle_out = ang_q;
  assign zero_out = zout_q;

endmodule

// File: tb/tb_cordic_vectoring_iter.sv
// Self-checking bench for cordic_vectoring_iter (default or GAIN_COMP_EN build).
module tb_cordic_vectoring_iter;

  localparam int IT = 32;
`ifdef GAIN_COMP_EN
  localparam int EXP_LAT = IT + 2;
  localparam real GAIN = 1.0;
`else
  localparam int EXP_LAT = IT + 1;
  localparam real GAIN = 1.646760258121;
`endif
  localparam longint PI2 = 64'd6746518852;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic in_ready;
  logic signed [31:0] x_in;
  logic signed [31:0] y_in;
  logic out_valid;
  logic out_ready;
  logic [33:0] mag_out;
  logic signed [34:0] angle_out;
  logic zero_out;

  int checks = 0;
  int failures = 0;
  longint atan_t [IT];

  logic signed [31:0] dx [7] = '{32'sd1000000, 32'sd1048576, -32'sd1048576,
    32'sd0, 32'sh8000_0000, 32'sh7FFF_FFFF, 32'sh8000_0000};
  logic signed [31:0] dy [7] = '{32'sd0, 32'sd1048576, 32'sd0,
    -32'sd1048576, 32'sh8000_0000, 32'sh8000_0000, 32'sd0};

  always #5 clk = ~clk;

  cordic_vectoring_iter dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x_in     (x_in),
    .y_in     (y_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .mag_out  (mag_out),
    .angle_out(angle_out),
    .zero_out (zero_out)
  );

  // Reference: quadrant fold, then ITER micro-rotations on wide integers
  function automatic void model(input longint xi, input longint yi,
      output longint mag, output longint ang, output bit zr);
    longint x, y, z, tx;
    logic [95:0] p;
    zr = (xi == 0) && (yi == 0);
    if (xi >= 0) begin
      x = xi; y = yi; z = 0;
    end else if (yi >= 0) begin
      x = yi; y = -xi; z = PI2;
    end else begin
      x = -yi; y = xi; z = -PI2;
    end
    for (int i = 0; i < IT; i++) begin
      tx = x;
      if (y >= 0) begin
        x = x + (y >>> i); y = y - (tx >>> i); z = z + atan_t[i];
      end else begin
        x = x - (y >>> i); y = y + (tx >>> i); z = z - atan_t[i];
      end
    end
`ifdef GAIN_COMP_EN
    p = 96'(x) * 96'h9B74EDA8 + 96'h8000_0000;
    x = longint'(p >> 32);
`else
    p = '0;
`endif
    mag = zr ? 0 : x;
    ang = zr ? 0 : z;
  endfunction

  function automatic longint adiff(input longint a, input longint b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic drive_vec(input logic signed [31:0] xv,
      input logic signed [31:0] yv, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b1;
    x_in = xv;
    y_in = yv;
    @(negedge clk);
    in_valid = 1'b0;
    x_in = $urandom;
    y_in = $urandom;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b0;
    x_in = 32'sd5;
    y_in = 32'sd7;
    repeat (3) @(negedge clk);
    checks++;
    if ({out_valid, in_ready, zero_out} !== 3'b010) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=010",
        {out_valid, in_ready, zero_out});
    end
    checks++;
    if (mag_out !== '0 || angle_out !== '0) begin
      failures++;
      $display("FAIL reset_data got=%0d/%0d exp=0/0", mag_out, angle_out);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    int lat;
    longint em, ea;
    bit ez;
    real r, ia, im, tol;
    for (int k = 0; k < 7; k++) begin
      drive_vec(dx[k], dy[k], lat);
      model(longint'(dx[k]), longint'(dy[k]), em, ea, ez);
      checks++;
      if (lat != EXP_LAT) begin
        failures++;
        $display("FAIL dir_lat[%0d] got=%0d exp=%0d", k, lat, EXP_LAT);
      end
      checks++;
      if (longint'(mag_out) != em) begin
        failures++;
        $display("FAIL dir_mag[%0d] got=%0d exp=%0d", k, mag_out, em);
      end
      checks++;
      if (adiff(longint'(angle_out), ea) > 2) begin
        failures++;
        $display("FAIL dir_ang[%0d] got=%0d exp=%0d", k,
          longint'(angle_out), ea);
      end
      r = $sqrt(real'(dx[k]) * real'(dx[k]) + real'(dy[k]) * real'(dy[k]));
      ia = $atan2(real'(dy[k]), real'(dx[k])) * 4294967296.0;
      im = GAIN * r;
      tol = 64.0 + 4294967296.0 * 64.0 / r;
      checks++;
      if (real'(angle_out) - ia > tol || ia - real'(angle_out) > tol) begin
        failures++;
        $display("FAIL dir_ideal_ang[%0d] got=%0d exp=%0.1f", k,
          longint'(angle_out), ia);
      end
      checks++;
      if (real'(mag_out) - im > 128.0 || im - real'(mag_out) > 128.0) begin
        failures++;
        $display("FAIL dir_ideal_mag[%0d] got=%0d exp=%0.1f", k,
          mag_out, im);
      end
      if (dy[k] == 0 && dx[k] < 0) begin
        checks++;
        if (angle_out <= 0) begin
          failures++;
          $display("FAIL dir_plus_pi[%0d] got=%0d exp=+pi", k,
            longint'(angle_out));
        end
      end
      ack();
    end
  endtask

  task automatic test_zero();
    int lat;
    drive_vec(32'sd0, 32'sd0, lat);
    checks++;
    if (lat != EXP_LAT) begin
      failures++;
      $display("FAIL zero_lat got=%0d exp=%0d", lat, EXP_LAT);
    end
    checks++;
    if ({zero_out, mag_out, angle_out} !== {1'b1, 34'd0, 35'sd0}) begin
      failures++;
      $display("FAIL zero_out got=%b/%0d/%0d exp=1/0/0",
        zero_out, mag_out, angle_out);
    end
    ack();
  endtask

  task automatic test_backpressure();
    int lat;
    longint em, ea;
    bit ez;
    logic [33:0] m0;
    logic signed [34:0] a0;
    drive_vec(32'sd300000, -32'sd700000, lat);
    model(64'sd300000, -64'sd700000, em, ea, ez);
    m0 = mag_out;
    a0 = angle_out;
    checks++;
    if (longint'(m0) != em || adiff(longint'(a0), ea) > 2) begin
      failures++;
      $display("FAIL bp_result got=%0d/%0d exp=%0d/%0d", m0,
        longint'(a0), em, ea);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, mag_out, angle_out} !== {1'b1, 1'b0, m0, a0})
      begin
        failures++;
        $display("FAIL bp_hold[%0d] got=%b%b/%0d/%0d exp=10/%0d/%0d", c,
          out_valid, in_ready, mag_out, angle_out, m0, a0);
      end
    end
    ack();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL bp_release got=%b exp=01", {out_valid, in_ready});
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    longint em, ea;
    bit ez;
    in_valid = 1'b1;
    x_in = 32'sd123456;
    y_in = 32'sd654321;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready, zero_out, mag_out, angle_out}
        !== {1'b0, 1'b1, 1'b0, 34'd0, 35'sd0}) begin
      failures++;
      $display("FAIL rst_mid got=%b%b%b/%0d/%0d exp=010/0/0",
        out_valid, in_ready, zero_out, mag_out, angle_out);
    end
    rst = 1'b0;
    drive_vec(-32'sd2000000, 32'sd500000, lat);
    model(-64'sd2000000, 64'sd500000, em, ea, ez);
    checks++;
    if (lat != EXP_LAT || longint'(mag_out) != em
        || adiff(longint'(angle_out), ea) > 2) begin
      failures++;
      $display("FAIL rst_next got=%0d/%0d/%0d exp=%0d/%0d/%0d", lat,
        mag_out, longint'(angle_out), EXP_LAT, em, ea);
    end
    ack();
  endtask

  task automatic test_back_to_back();
    logic signed [31:0] ax, ay, bx, by;
    longint em, ea;
    bit ez;
    int n;
    ax = 32'sd777777; ay = -32'sd111111;
    bx = -32'sd999; by = -32'sd4444444;
    out_ready = 1'b1;
    in_valid = 1'b1;
    x_in = ax;
    y_in = ay;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ready0 got=%b exp=1", in_ready);
    end
    @(negedge clk);
    x_in = bx;
    y_in = by;
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    model(longint'(ax), longint'(ay), em, ea, ez);
    checks++;
    if (n != EXP_LAT || in_ready !== 1'b0 || longint'(mag_out) != em
        || adiff(longint'(angle_out), ea) > 2) begin
      failures++;
      $display("FAIL b2b_a got=%0d/%b/%0d/%0d exp=%0d/0/%0d/%0d", n,
        in_ready, mag_out, longint'(angle_out), EXP_LAT, em, ea);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL b2b_gap got=%b exp=01", {out_valid, in_ready});
    end
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    model(longint'(bx), longint'(by), em, ea, ez);
    checks++;
    if (n != EXP_LAT || longint'(mag_out) != em
        || adiff(longint'(angle_out), ea) > 2 || zero_out !== 1'b0) begin
      failures++;
      $display("FAIL b2b_b got=%0d/%0d/%0d exp=%0d/%0d/%0d", n,
        mag_out, longint'(angle_out), EXP_LAT, em, ea);
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    int lat;
    longint em, ea;
    bit ez;
    logic signed [31:0] xv, yv;
    for (int k = 0; k < 30; k++) begin
      xv = $signed($urandom) >>> $urandom_range(0, 20);
      yv = $signed($urandom) >>> $urandom_range(0, 20);
      drive_vec(xv, yv, lat);
      model(longint'(xv), longint'(yv), em, ea, ez);
      checks++;
      if (lat != EXP_LAT || zero_out !== ez) begin
        failures++;
        $display("FAIL rnd_ctl[%0d] got=%0d/%b exp=%0d/%b", k, lat,
          zero_out, EXP_LAT, ez);
      end
      checks++;
      if (longint'(mag_out) != em) begin
        failures++;
        $display("FAIL rnd_mag[%0d] x=%0d y=%0d got=%0d exp=%0d", k,
          xv, yv, mag_out, em);
      end
      checks++;
      if (adiff(longint'(angle_out), ea) > 2) begin
        failures++;
        $display("FAIL rnd_ang[%0d] x=%0d y=%0d got=%0d exp=%0d", k,
          xv, yv, longint'(angle_out), ea);
      end
      ack();
    end
  endtask

  initial begin
    for (int i = 0; i < IT; i++)
      atan_t[i] = longint'($atan(1.0 / (2.0 ** i)) * 4294967296.0);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    x_in = '0;
    y_in = '0;
    test_reset();
    test_directed();
    test_zero();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
